spi_arbiter: RTL
================

SPI_ARBITER -- requirements
Module: spi_arbiter

Interface
REQ-001 The module SHALL have this parameter: TIMEOUT_CYCLES, 16'd65535, maximum cycles a launched transfer may take to complete.
REQ-002 The module SHALL have port clk_i, input, 1, the single clock; all logic is on its rising edge.
REQ-003 The module SHALL have port reset_n_i, input, 1, asynchronous active-low reset.
REQ-004 The module SHALL have port req_i, input, 2, transfer request per requester (bit0 = wishbone host path, bit1 = housekeeping poller).
REQ-005 The module SHALL have port req_sel_i, input, 4, device select per requester ([1:0] req0, [3:2] req1).
REQ-006 The module SHALL have port req_dat_i, input, 64, write word per requester ([31:0] req0, [63:32] req1).
REQ-007 The module SHALL have these outputs: gnt_o, 2, one-hot grant; done_o, 2, one-cycle completion pulse; err_o, 2, one-cycle timeout pulse; rdat_o, 32, read word; busy_o, 1, transfer in progress.
REQ-008 The module SHALL have these SPI engine ports: SPI_O, output, 32; SPI_SEL_O, output, 2; SPI_START_O, output, 1; SPI_I, input, 32; SPI_DONE_I, input, 1.

Function
REQ-009 The FSM SHALL have the states IDLE, LAUNCH, WAIT, FINISH and ERROR.
REQ-010 In IDLE with any req_i bit high, the FSM SHALL pick a winner, latch its req_sel_i/req_dat_i into SPI_SEL_O/SPI_O and go to LAUNCH; gnt_o and SPI_START_O go high one cycle after req_i is sampled.
REQ-011 Arbitration SHALL be round-robin: with one request, that requester wins; with both, the requester not served last wins; the last-served pointer resets to 1, so req0 wins first.
REQ-012 LAUNCH SHALL hold SPI_START_O high until SPI_DONE_I is sampled low, then go to WAIT with SPI_START_O low.
REQ-013 WAIT SHALL go to FINISH on the first cycle SPI_DONE_I is sampled high.
REQ-014 FINISH SHALL last exactly one cycle: capture SPI_I into rdat_o, pulse done_o[winner], clear gnt_o, update the last-served pointer and return to IDLE.
REQ-015 busy_o SHALL be high in every state except IDLE; SPI_O and SPI_SEL_O SHALL stay stable from LAUNCH through FINISH.
REQ-016 req_i changes after grant SHALL be ignored: a dropped request still completes and still receives done_o; the other requester's inputs are not sampled until IDLE.
REQ-017 A requester still high in the cycle after its done_o SHALL be treated as a new request and compete normally.
REQ-018 rdat_o SHALL hold its value until the next FINISH and SHALL be valid during and after done_o.

Reset
REQ-019 Asserting reset_n_i low SHALL asynchronously force IDLE, last-served pointer = 1, and these outputs to zero: gnt_o, done_o, err_o, rdat_o, busy_o, SPI_O, SPI_SEL_O, SPI_START_O, timeout counter.
REQ-020 A reset mid-transfer SHALL abandon the transfer with no done_o or err_o; the first request after deassertion SHALL be arbitrated from IDLE.

Configuration
REQ-021 With SPI_ARB_TIMEOUT_EN defined, a 16-bit counter SHALL clear on entry to LAUNCH, increment each cycle in LAUNCH/WAIT, and force ERROR when it equals TIMEOUT_CYCLES.
REQ-022 ERROR SHALL last one cycle: pulse err_o[winner] with no done_o, drive SPI_START_O low, leave rdat_o unchanged, clear gnt_o, update the pointer and return to IDLE.
REQ-023 If the timeout and SPI_DONE_I high coincide in WAIT, completion (FINISH) SHALL win.
REQ-024 Without SPI_ARB_TIMEOUT_EN, the counter and ERROR state SHALL be absent, err_o SHALL be tied to 2'b00, and WAIT/LAUNCH SHALL wait indefinitely.

Verification
REQ-025 The bench SHALL cover: req_i=01 with sel=2, dat=0xA5A5_0001; engine drops DONE 2 cycles after start and raises it 10 cycles later, returning 0x1234_5678 -> SPI_SEL_O=2, SPI_O=0xA5A5_0001, then done_o=01 with rdat_o=0x1234_5678.
REQ-026 The bench SHALL cover: req_i=11 held for 3 transfers -> grant order req0, req1, req0, with exactly one done_o pulse each.
REQ-027 The bench SHALL cover: req1 drops in WAIT -> transfer completes and done_o=10 is still pulsed.
REQ-028 The bench SHALL cover (macro on, TIMEOUT_CYCLES=20): SPI_DONE_I never falls -> err_o=01 pulse 20 cycles after LAUNCH entry, SPI_START_O low, rdat_o unchanged; the same stimulus with the macro off stays in LAUNCH with busy_o=1.
REQ-029 The bench SHALL cover: reset_n_i low during WAIT -> all outputs 0 immediately, no done_o; the next req_i=10 is granted to req1 at reset-exit+1 cycle.

Source files
------------

// File: rtl/spi_arbiter.sv
`default_nettype none
// +----------------------------------------------------------------------------+
// | Module      : spi_arbiter                                                  |
// | Description : Two-requester round-robin arbiter in front of a shared SPI   |
// |               engine. The winner's select/word are latched and launched;   |
// |               the engine's read word is returned with a one-cycle done.    |
// | Revision    : 1.0  initial release                                         |
// +----------------------------------------------------------------------------+
// | Ports                                                                      |
// |   clk_i        rising-edge clock                                           |
// |   reset_n_i    asynchronous active-low reset                               |
// |   req_i[1:0]   request (bit0 wishbone host, bit1 housekeeping poller)      |
// |   req_sel_i    device select per requester ([1:0] req0, [3:2] req1)        |
// |   req_dat_i    write word per requester ([31:0] req0, [63:32] req1)        |
// |   gnt_o        one-hot grant, held from launch until completion            |
// |   done_o       one-cycle completion pulse for the served requester         |
// |   err_o        one-cycle timeout pulse for the served requester            |
// |   rdat_o       read word, held until the next completion                   |
// |   busy_o       transfer in progress                                        |
// |   SPI_O / SPI_SEL_O / SPI_START_O   command to the SPI engine              |
// |   SPI_I / SPI_DONE_I                read word / ready from the SPI engine  |
// | Build option                                                               |
// |   SPI_ARB_TIMEOUT_EN  adds a transfer timeout counter and ERROR state      |
// +----------------------------------------------------------------------------+
module spi_arbiter #(
  parameter logic [15:0] TIMEOUT_CYCLES = 16'd65535
) (
  input  logic        clk_i,
  input  logic        reset_n_i,
  input  logic [1:0]  req_i,
  input  logic [3:0]  req_sel_i,
  input  logic [63:0] req_dat_i,
  output logic [1:0]  gnt_o,
  output logic [1:0]  done_o,
  output logic [1:0]  err_o,
  output logic [31:0] rdat_o,
  output logic        busy_o,
  output logic [31:0] SPI_O,
  output logic [1:0]  SPI_SEL_O,
  output logic        SPI_START_O,
  input  logic [31:0] SPI_I,
  input  logic        SPI_DONE_I
);

  typedef enum logic [2:0] {
    S_IDLE   = 3'd0,
    S_LAUNCH = 3'd1,
    S_WAIT   = 3'd2,
    S_FINISH = 3'd3
`ifdef SPI_ARB_TIMEOUT_EN
    ,S_ERROR = 3'd4
`endif
  } state_t;

  state_t      r_state, w_state_nxt;
  logic        r_last,  w_last_nxt;     // index of the requester served last
  logic        r_winner, w_winner_nxt;
  logic [1:0]  r_gnt,   w_gnt_nxt;
  logic [1:0]  r_done,  w_done_nxt;
  logic [31:0] r_rdat,  w_rdat_nxt;
  logic        r_busy,  w_busy_nxt;
  logic [31:0] r_spi_dat, w_spi_dat_nxt;
  logic [1:0]  r_spi_sel, w_spi_sel_nxt;
  logic        r_start, w_start_nxt;
  logic        w_pick;
  logic [1:0]  w_win_oh;

`ifdef SPI_ARB_TIMEOUT_EN
  logic [15:0] r_cnt, w_cnt_nxt;
  logic [1:0]  r_err, w_err_nxt;
`endif

  // Round-robin pick: a lone request always wins; on contention the
  // requester that was not served last wins.
  always_comb begin
    case (req_i)
      2'b01:   w_pick = 1'b0;
      2'b10:   w_pick = 1'b1;
      default: w_pick = ~r_last;
    endcase
  end

  assign w_win_oh = r_winner ? 2'b10 : 2'b01;

  always_comb begin
    w_state_nxt   = r_state;
    w_last_nxt    = r_last;
    w_winner_nxt  = r_winner;
    w_gnt_nxt     = r_gnt;
    w_done_nxt    = 2'b00;
    w_rdat_nxt    = r_rdat;
    w_spi_dat_nxt = r_spi_dat;
    w_spi_sel_nxt = r_spi_sel;
    w_start_nxt   = r_start;
`ifdef SPI_ARB_TIMEOUT_EN
    w_cnt_nxt     = r_cnt;
    w_err_nxt     = 2'b00;
`endif
    case (r_state)
      S_IDLE: begin
        if (|req_i) begin
          w_state_nxt   = S_LAUNCH;
          w_winner_nxt  = w_pick;
          w_gnt_nxt     = w_pick ? 2'b10 : 2'b01;
          w_spi_sel_nxt = w_pick ? req_sel_i[3:2]   : req_sel_i[1:0];
          w_spi_dat_nxt = w_pick ? req_dat_i[63:32] : req_dat_i[31:0];
          w_start_nxt   = 1'b1;
`ifdef SPI_ARB_TIMEOUT_EN
          w_cnt_nxt     = 16'd0;
`endif
        end
      end
      S_LAUNCH: begin
        // The engine acknowledges the start by dropping its ready flag.
        if (!SPI_DONE_I) begin
          w_state_nxt = S_WAIT;
          w_start_nxt = 1'b0;
        end
`ifdef SPI_ARB_TIMEOUT_EN
        w_cnt_nxt = r_cnt + 16'd1;
        if (w_cnt_nxt == TIMEOUT_CYCLES) begin
          w_state_nxt = S_ERROR;
          w_start_nxt = 1'b0;
          w_err_nxt   = w_win_oh;
          w_gnt_nxt   = 2'b00;
          w_last_nxt  = r_winner;
        end
`endif
      end
      S_WAIT: begin
`ifdef SPI_ARB_TIMEOUT_EN
        w_cnt_nxt = r_cnt + 16'd1;
`endif
        // Completion takes priority over a coincident timeout.
        if (SPI_DONE_I) begin
          w_state_nxt = S_FINISH;
          w_rdat_nxt  = SPI_I;
          w_done_nxt  = w_win_oh;
          w_gnt_nxt   = 2'b00;
          w_last_nxt  = r_winner;
        end
`ifdef SPI_ARB_TIMEOUT_EN
        else if (w_cnt_nxt == TIMEOUT_CYCLES) begin
          w_state_nxt = S_ERROR;
          w_start_nxt = 1'b0;
          w_err_nxt   = w_win_oh;
          w_gnt_nxt   = 2'b00;
          w_last_nxt  = r_winner;
        end
`endif
      end
      S_FINISH: w_state_nxt = S_IDLE;
`ifdef SPI_ARB_TIMEOUT_EN
      S_ERROR:  w_state_nxt = S_IDLE;
`endif
      default:  w_state_nxt = S_IDLE;
    endcase
    w_busy_nxt = (w_state_nxt != S_IDLE);
  end

  always_ff @(posedge clk_i or negedge reset_n_i) begin
    if (!reset_n_i) r_state <= S_IDLE;
    else            r_state <= w_state_nxt;
  end

  // Outputs are registered from the next-state decode so each one changes
  // on the same edge as the state transition that causes it.
  always_ff @(posedge clk_i or negedge reset_n_i) begin
    if (!reset_n_i) begin
      r_last    <= 1'b1;
      r_winner  <= 1'b0;
      r_gnt     <= 2'b00;
      r_done    <= 2'b00;
      r_rdat    <= 32'd0;
      r_busy    <= 1'b0;
      r_spi_dat <= 32'd0;
      r_spi_sel <= 2'b00;
      r_start   <= 1'b0;
    end else begin
      r_last    <= w_last_nxt;
      r_winner  <= w_winner_nxt;
      r_gnt     <= w_gnt_nxt;
      r_done    <= w_done_nxt;
      r_rdat    <= w_rdat_nxt;
      r_busy    <= w_busy_nxt;
      r_spi_dat <= w_spi_dat_nxt;
      r_spi_sel <= w_spi_sel_nxt;
      r_start   <= w_start_nxt;
    end
  end

`ifdef SPI_ARB_TIMEOUT_EN
  always_ff @(posedge clk_i or negedge reset_n_i) begin
    if (!reset_n_i) begin
      r_cnt <= 16'd0;
      r_err <= 2'b00;
    end else begin
      r_cnt <= w_cnt_nxt;
      r_err <= w_err_nxt;
    end
  end
  assign err_o = r_err;
`else
  logic w_unused_timeout;
  assign w_unused_timeout = ^TIMEOUT_CYCLES;
  assign err_o = 2'b00;
`endif

  assign gnt_o       = r_gnt;
  assign done_o      = r_done;
  assign rdat_o      = r_rdat;
  assign busy_o      = r_busy;
  assign SPI_O       = r_spi_dat;
  assign SPI_SEL_O   = r_spi_sel;
  assign SPI_START_O = r_start;

endmodule
`default_nettype wire
